regfile_mp: RTL

Parametrised multi-port integer register file with write-bypass and a per-register pending-write scoreboard. It is the next-generation register file for the core, supporting dual-issue or out-of-order writeback. It sits between decode (read ports, issue-side scoreboard set) and writeback (write ports, scoreboard clear). Register 0 is optionally hardwired to zero.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_mp_scoreboard.sv | 50 +++++
 rtl/regfile_mp.sv | 101 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: address width and
// parameter range limits checked by the top at elaboration.
package regfile_pkg;

  localparam int NRD_MIN = 1;
  localparam int NRD_MAX = 4;
  localparam int NWR_MIN = 1;
  localparam int NWR_MAX = 3;

  function automatic int addr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy flop per register. An issue to the
// same register as a writeback in the same cycle wins (new producer).
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int NWR      = 1,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              iss_en_i,
  input  logic [AW-1:0]     iss_addr_i,
  output logic [NREG-1:0]   busy_o
);

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [NWR-1:0] wr_hit;
    logic           iss_hit;

    for (genvar gj = 0; gj < NWR; gj++) begin : g_wr
      assign wr_hit[gj] = wr_en_i[gj] && (wr_addr_i[gj*AW +: AW] == AW'(gi));
    end

    assign iss_hit = iss_en_i && (iss_addr_i == AW'(gi));

    if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
      assign busy_next[gi] = 1'b0;
    end else begin : g_norm
      assign busy_next[gi] = iss_hit ? 1'b1 : ((|wr_hit) ? 1'b0 : busy_reg[gi]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign busy_o = busy_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional same-cycle write bypass, optional
// hardwired-zero register 0 and a pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int  NREG     = 32,
  parameter int  WIDTH    = 32,
  parameter int  NRD      = 2,
  parameter int  NWR      = 1,
  parameter int  BYPASS   = 1,
  parameter int  ZERO_REG = 1,
  localparam int AW       = addr_width(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic [NRD*AW-1:0]    rd_addr_i,
  output logic [NRD*WIDTH-1:0] rd_data_o,
  output logic [NRD-1:0]       rd_busy_o,
  input  logic [NWR-1:0]       wr_en_i,
  input  logic [NWR*AW-1:0]    wr_addr_i,
  input  logic [NWR*WIDTH-1:0] wr_data_i,
  input  logic                 iss_en_i,
  input  logic [AW-1:0]        iss_addr_i,
  output logic [NREG-1:0]      busy_o
);

  if (!in_range(NRD, NRD_MIN, NRD_MAX)) begin : g_bad_nrd
    $error("regfile_mp: NRD out of range");
  end
  if (!in_range(NWR, NWR_MIN, NWR_MAX)) begin : g_bad_nwr
    $error("regfile_mp: NWR out of range");
  end
  if (!is_pow2(NREG)) begin : g_bad_nreg
    $error("regfile_mp: NREG must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_reg [NREG];
  logic [NREG-1:0]  busy_vec;

  // Ascending port order makes the highest-index writer win on collisions.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        mem_reg[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en_i[j] && !((ZERO_REG != 0) && (wr_addr_i[j*AW +: AW] == '0))) begin
          mem_reg[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  rf_scoreboard #(
    .NREG     (NREG),
    .NWR      (NWR),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .busy_o     (busy_vec)
  );

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data_sel;
    logic             busy_sel;

    assign addr = rd_addr_i[gi*AW +: AW];

    // Forwarded data is already in flight, so the register no longer waits.
    always_comb begin
      data_sel = mem_reg[addr];
      busy_sel = busy_vec[addr];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == addr)) begin
            data_sel = wr_data_i[j*WIDTH +: WIDTH];
            busy_sel = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data_sel = '0;
        busy_sel = 1'b0;
      end
    end

    assign rd_data_o[gi*WIDTH +: WIDTH] = data_sel;
    assign rd_busy_o[gi]                = busy_sel;
  end

  assign busy_o = busy_vec;

endmodule
